// File: rtl/tp_sram_pkg.sv
// Shared types for the two-port SRAM: collision policy and clear-sweep FSM states.
package tp_sram_pkg;

    typedef enum logic {
        READ_FIRST,
        WRITE_FIRST
    } rdw_mode_e;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

endpackage

// File: rtl/sram_be_expand.sv
// Expands byte enables to a per-bit write mask; the top enable also covers a partial byte.
module sram_be_expand #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [(DATA_WIDTH+7)/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]       mask_o
);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        assign mask_o[i] = be_i[i/8];
    end

endmodule

// File: rtl/tp_sram.sv
// One-write/one-read SRAM with byte enables, pipelined reads and a zeroisation sweep.
module tp_sram
    import tp_sram_pkg::*;
#(
    parameter string     INIT_FILE    = "",
    parameter int        DATA_WIDTH   = 64,
    parameter int        NUM_WORDS    = 1024,
    parameter int        READ_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE     = READ_FIRST,
    localparam int       AW           = $clog2(NUM_WORDS),
    localparam int       BEW          = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wreq_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BEW-1:0]        be_i,
    input  logic                  rreq_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  clr_req_i,
    output logic                  clr_busy_o
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "tp_sram: READ_LATENCY must be 1 or 2");
    end

    localparam logic [AW:0]   DEPTH = (AW + 1)'(NUM_WORDS);
    localparam logic [AW-1:0] LAST  = AW'(NUM_WORDS - 1);

    typedef struct packed {
        logic                  en;
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    clr_state_e state_q, state_d;
    logic [AW-1:0] cnt_q;
    logic          clr_busy;

    logic                  wr_acc, rd_acc, rd_hit;
    logic [DATA_WIDTH-1:0] wmask, rd_word;
    wr_req_t               wr;

    logic [READ_LATENCY:1]                 vld_pipe;
    logic [READ_LATENCY:1][DATA_WIDTH-1:0] rd_pipe;

    sram_be_expand #(.DATA_WIDTH(DATA_WIDTH)) u_be (
        .be_i   (be_i),
        .mask_o (wmask)
    );

    // Power-up contents are all zero.
    if (1) begin : g_preload
        initial begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;
        end
    end

    assign wr_acc = wreq_i && !clr_busy && ({1'b0, waddr_i} < DEPTH);
    assign rd_acc = rreq_i && !clr_busy;
    assign rd_hit = {1'b0, raddr_i} < DEPTH;

    // The sweep owns the write port; user writes are never accepted while it runs.
    always_comb begin
        wr.en   = clr_busy || wr_acc;
        wr.addr = clr_busy ? cnt_q : waddr_i;
        wr.data = clr_busy ? '0 : ((mem[waddr_i] & ~wmask) | (wdata_i & wmask));
    end

    always_ff @(posedge clk_i) begin
        if (wr.en) mem[wr.addr] <= wr.data;
    end

    always_comb begin
        rd_word = '0;
        if (rd_hit) begin
            rd_word = mem[raddr_i];
            if (RDW_MODE == WRITE_FIRST && wr_acc && waddr_i == raddr_i)
                rd_word = (rd_word & ~wmask) | (wdata_i & wmask);
        end
    end

    // Data stages only load on a valid beat, so rdata_o holds between pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc) rd_pipe[1] <= rd_word;
            for (int s = 2; s <= READ_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) rd_pipe[s] <= rd_pipe[s-1];
            end
        end
    end

    assign rvalid_o = vld_pipe[READ_LATENCY];
    assign rdata_o  = rd_pipe[READ_LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req_i) state_d = CLEAR;
            CLEAR:   if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (state_q == CLEAR);
    end

    assign clr_busy_o = clr_busy;

endmodule
